// File: rtl/add_acc_n.sv
// rtl/add_acc_n.sv - synchronised add/sub/step-accumulate datapath with key debounce, LED mirror and hex display
`timescale 1ns/1ps

module add_acc_n #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16,
    localparam int NDIG       = (WIDTH + 4) / 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     sw_a,
    input  logic [WIDTH-1:0]     sw_b,
    input  logic                 sw_cin,
    input  logic [1:0]           mode,
    input  logic                 key_n,
    output logic [WIDTH-1:0]     sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 press,
    output logic [2*WIDTH:0]     led,
    output logic [7*NDIG-1:0]    hex
);

    typedef enum logic [1:0] {
        M_ADD  = 2'b00,
        M_ACC  = 2'b01,
        M_SUB  = 2'b10,
        M_HOLD = 2'b11
    } mode_t;

    localparam int CW = $clog2(DEB_CYCLES);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] a_sr, b_sr;
    logic [SYNC_STAGES-1:0][1:0]       mode_sr;
    logic [SYNC_STAGES-1:0]            cin_sr, key_sr;

    logic [WIDTH-1:0] a_s, b_s;
    logic             cin_s, key_s;
    mode_t            mode_s;

    // Every raw board input is asynchronous; all chains share one depth so
    // operands and mode arrive at the datapath on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            mode_sr <= '0;
            cin_sr  <= '0;
            key_sr  <= '1;
        end else begin
            a_sr    <= {a_sr[SYNC_STAGES-2:0], sw_a};
            b_sr    <= {b_sr[SYNC_STAGES-2:0], sw_b};
            mode_sr <= {mode_sr[SYNC_STAGES-2:0], mode};
            cin_sr  <= {cin_sr[SYNC_STAGES-2:0], sw_cin};
            key_sr  <= {key_sr[SYNC_STAGES-2:0], key_n};
        end
    end

    assign a_s    = a_sr[SYNC_STAGES-1];
    assign b_s    = b_sr[SYNC_STAGES-1];
    assign cin_s  = cin_sr[SYNC_STAGES-1];
    assign key_s  = key_sr[SYNC_STAGES-1];
    assign mode_s = mode_t'(mode_sr[SYNC_STAGES-1]);
    assign led    = {cin_s, b_s, a_s};

    logic          deb_level;
    logic [CW-1:0] deb_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            press <= 1'b0;
            if (key_s == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                deb_level <= key_s;
                deb_cnt   <= '0;
                press     <= deb_level;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    logic [WIDTH:0] add_res, sub_res, acc_res;

    always_comb begin
        add_res = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
        sub_res = {1'b0, a_s} + {1'b0, ~b_s} + (WIDTH+1)'(1);
        acc_res = {1'b0, sum} + {1'b0, a_s} + {{WIDTH{1'b0}}, cin_s};
    end

    function automatic logic ovf_of(input logic x_msb, input logic y_msb, input logic r_msb);
        return (x_msb == y_msb) && (r_msb != x_msb);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (mode_s)
                M_ADD: begin
                    {cout, sum} <= add_res;
                    ovf <= ovf_of(a_s[WIDTH-1], b_s[WIDTH-1], add_res[WIDTH-1]);
                end
                M_SUB: begin
                    {cout, sum} <= sub_res;
                    ovf <= ovf_of(a_s[WIDTH-1], ~b_s[WIDTH-1], sub_res[WIDTH-1]);
                end
                M_ACC: begin
                    if (press) begin
                        {cout, sum} <= acc_res;
                        ovf <= ovf_of(sum[WIDTH-1], a_s[WIDTH-1], acc_res[WIDTH-1]);
                    end
                end
                default: begin
                    if (press) begin
                        sum  <= '0;
                        cout <= 1'b0;
                        ovf  <= 1'b0;
                    end
                end
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    logic [4*NDIG-1:0] disp_val;

    always_comb begin
        disp_val = '0;
        disp_val[WIDTH:0] = {cout, sum};
    end

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        assign hex[7*i +: 7] = seg7(disp_val[4*i +: 4]);
    end

endmodule

// File: tb/tb_add_acc_n.sv
// tb/tb_add_acc_n.sv - directed self-checking bench for add_acc_n
`timescale 1ns/1ps

module tb_add_acc_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sw_a, sw_b;
    logic        sw_cin;
    logic [1:0]  mode;
    logic        key_n;
    logic [3:0]  sum;
    logic        cout, ovf, press;
    logic [8:0]  led;
    logic [13:0] hex;

    int compared = 0;
    int mismatched = 0;
    int press_cnt = 0;

    add_acc_n #(.WIDTH(4), .SYNC_STAGES(2), .DEB_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .sw_a(sw_a), .sw_b(sw_b), .sw_cin(sw_cin),
        .mode(mode), .key_n(key_n), .sum(sum), .cout(cout), .ovf(ovf),
        .press(press), .led(led), .hex(hex)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (press === 1'b1) press_cnt = press_cnt + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sw_a = 4'd0; sw_b = 4'd0; sw_cin = 1'b0; mode = 2'b00; key_n = 1'b1;
        tick(3);
        compared++; if (sum !== 4'd0) begin mismatched++; $display("FAIL reset_sum actual=%0d expected=0", sum); end
        compared++; if (cout !== 1'b0 || ovf !== 1'b0) begin mismatched++; $display("FAIL reset_flags actual=%b%b expected=00", cout, ovf); end
        compared++; if (press !== 1'b0) begin mismatched++; $display("FAIL reset_press actual=%b expected=0", press); end
        compared++; if (led !== 9'd0) begin mismatched++; $display("FAIL reset_led actual=%h expected=0", led); end
        compared++; if (hex !== {7'h40, 7'h40}) begin mismatched++; $display("FAIL reset_hex actual=%h expected=%h", hex, {7'h40, 7'h40}); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        mode = 2'b00; sw_a = 4'd9; sw_b = 4'd8; sw_cin = 1'b1;
        tick(2);
        compared++; if (led !== 9'b1_1000_1001) begin mismatched++; $display("FAIL add_led actual=%b expected=110001001", led); end
        tick(1);
        compared++; if (sum !== 4'd2) begin mismatched++; $display("FAIL add_sum actual=%0d expected=2", sum); end
        compared++; if (cout !== 1'b1 || ovf !== 1'b1) begin mismatched++; $display("FAIL add_flags actual=%b%b expected=11", cout, ovf); end
        compared++; if (hex[6:0] !== 7'b0100100) begin mismatched++; $display("FAIL add_hex0 actual=%b expected=0100100", hex[6:0]); end
        compared++; if (hex[13:7] !== 7'b1111001) begin mismatched++; $display("FAIL add_hex1 actual=%b expected=1111001", hex[13:7]); end
        sw_a = 4'd3; sw_b = 4'd4; sw_cin = 1'b0;
        tick(3);
        compared++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 4'd7}) begin mismatched++; $display("FAIL add2 actual=%b%b/%0d expected=00/7", cout, ovf, sum); end
    endtask

    task automatic test_bounce();
        mode = 2'b01; sw_a = 4'd3; sw_b = 4'd0; sw_cin = 1'b0; key_n = 1'b1;
        do_reset();
        tick(3);
        press_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(5);
        end
        compared++; if (press_cnt !== 0) begin mismatched++; $display("FAIL bounce_nopress actual=%0d expected=0", press_cnt); end
        key_n = 1'b0;
        tick(40);
        compared++; if (press_cnt !== 1) begin mismatched++; $display("FAIL bounce_press actual=%0d expected=1", press_cnt); end
        compared++; if (sum !== 4'd3 || cout !== 1'b0) begin mismatched++; $display("FAIL bounce_sum actual=%0d/%b expected=3/0", sum, cout); end
        key_n = 1'b1;
        tick(30);
        compared++; if (press_cnt !== 1 || sum !== 4'd3) begin mismatched++; $display("FAIL release_nopulse actual=%0d/%0d expected=1/3", press_cnt, sum); end
    endtask

    task automatic clean_press();
        key_n = 1'b0;
        tick(25);
        key_n = 1'b1;
        tick(25);
    endtask

    task automatic test_acc_wrap();
        mode = 2'b01; sw_a = 4'd7; sw_b = 4'd0; sw_cin = 1'b0; key_n = 1'b1;
        do_reset();
        tick(3);
        clean_press();
        compared++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 4'd7}) begin mismatched++; $display("FAIL acc1 actual=%b%b/%0d expected=00/7", cout, ovf, sum); end
        clean_press();
        compared++; if ({cout, ovf, sum} !== {1'b0, 1'b1, 4'd14}) begin mismatched++; $display("FAIL acc2 actual=%b%b/%0d expected=01/14", cout, ovf, sum); end
        clean_press();
        compared++; if ({cout, ovf, sum} !== {1'b1, 1'b0, 4'd5}) begin mismatched++; $display("FAIL acc3 actual=%b%b/%0d expected=10/5", cout, ovf, sum); end
    endtask

    task automatic test_hold();
        mode = 2'b11;
        tick(5);
        compared++; if ({cout, sum} !== {1'b1, 4'd5}) begin mismatched++; $display("FAIL hold_keep actual=%b/%0d expected=1/5", cout, sum); end
        clean_press();
        compared++; if ({cout, ovf, sum} !== 6'd0) begin mismatched++; $display("FAIL hold_clear actual=%b%b/%0d expected=00/0", cout, ovf, sum); end
    endtask

    task automatic test_reset_mid_debounce();
        mode = 2'b01; sw_a = 4'd7; sw_b = 4'd0; sw_cin = 1'b0;
        tick(3);
        press_cnt = 0;
        key_n = 1'b0;
        tick(12);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(16);
        compared++; if (press_cnt !== 0) begin mismatched++; $display("FAIL rst_deb_nopress actual=%0d expected=0", press_cnt); end
        tick(10);
        compared++; if (press_cnt !== 1) begin mismatched++; $display("FAIL rst_deb_press actual=%0d expected=1", press_cnt); end
        compared++; if (sum !== 4'd7) begin mismatched++; $display("FAIL rst_deb_sum actual=%0d expected=7", sum); end
        key_n = 1'b1;
        tick(25);
    endtask

    task automatic test_sub();
        mode = 2'b10; sw_a = 4'd3; sw_b = 4'd5; sw_cin = 1'b1;
        tick(3);
        compared++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 4'd14}) begin mismatched++; $display("FAIL sub1 actual=%b%b/%0d expected=00/14", cout, ovf, sum); end
        compared++; if (hex !== {7'h40, 7'h06}) begin mismatched++; $display("FAIL sub1_hex actual=%h expected=%h", hex, {7'h40, 7'h06}); end
        sw_a = 4'd8; sw_b = 4'd1;
        tick(3);
        compared++; if ({cout, ovf, sum} !== {1'b1, 1'b1, 4'd7}) begin mismatched++; $display("FAIL sub2 actual=%b%b/%0d expected=11/7", cout, ovf, sum); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_bounce();
        test_acc_wrap();
        test_hold();
        test_reset_mid_debounce();
        test_sub();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
